// File: rtl/exu_pkg.sv
// Shared encodings for the execute stage: ALU ops, operand selects and memory widths.
// Used by both the decoder and exu so the control encodings stay in one place.
package exu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SHAMT_W  = 5;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_SEQ   = 4'd11,
        ALU_SNE   = 4'd12,
        ALU_SGE   = 4'd13,
        ALU_SGEU  = 4'd14,
        ALU_ADD2  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        A_DATA1 = 2'd0,
        A_PC    = 2'd1,
        A_ZERO  = 2'd2,
        A_ZERO2 = 2'd3
    } alu_a_src_e;

    typedef enum logic [1:0] {
        B_DATA2 = 2'd0,
        B_IMM   = 2'd1,
        B_FOUR  = 2'd2,
        B_ZERO  = 2'd3
    } alu_b_src_e;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    // One RAM word write: per-lane enables plus lane-replicated data
    typedef struct packed {
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } store_req_t;

endpackage

// File: rtl/exu_alu.sv
// Combinational ALU for the execute stage; compares return 0/1, shifts use b[4:0].
module exu_alu
    import exu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result_c
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD,
            ALU_ADD2:  result_c = a + b;
            ALU_SUB:   result_c = a - b;
            ALU_SLL:   result_c = a << shamt;
            ALU_SLT:   result_c = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  result_c = XLEN'(a < b);
            ALU_XOR:   result_c = a ^ b;
            ALU_SRL:   result_c = a >> shamt;
            ALU_SRA:   result_c = XLEN'($signed(a) >>> shamt);
            ALU_OR:    result_c = a | b;
            ALU_AND:   result_c = a & b;
            ALU_PASSB: result_c = b;
            ALU_SEQ:   result_c = XLEN'(a == b);
            ALU_SNE:   result_c = XLEN'(a != b);
            ALU_SGE:   result_c = XLEN'($signed(a) >= $signed(b));
            ALU_SGEU:  result_c = XLEN'(a >= b);
            default:   result_c = '0;
        endcase
    end

endmodule

// File: rtl/exu.sv
// Execute stage: operand muxing, ALU, zero-latency data RAM and next-PC generation.
// Loads and outputs are combinational; only RAM writes happen on the clock edge.
module exu
    import exu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [1:0]      ALUAsrc,
    input  logic [1:0]      ALUBsrc,
    input  logic [3:0]      ALUop,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic [2:0]      MemOp,
    input  logic            PCAsrc,
    input  logic            PCBsrc,
    input  logic            branch,
    input  logic            ebreak,
    output logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] pc_next
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  result;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  rd_word;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [XLEN-1:0]  load_val;
    store_req_t       st_req;
    logic             wr_en;
    logic             taken;
    logic [XLEN-1:0]  pc_base;
    logic [XLEN-1:0]  pc_sum;
    logic [XLEN-1:0]  pc_target;

    logic [XLEN-1:0]  mem [MEM_WORDS];

    always_comb begin
        op_a = '0;
        case (alu_a_src_e'(ALUAsrc))
            A_DATA1: op_a = data1;
            A_PC:    op_a = pc;
            default: op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (alu_b_src_e'(ALUBsrc))
            B_DATA2: op_b = data2;
            B_IMM:   op_b = imm;
            B_FOUR:  op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    exu_alu u_alu (
        .a        (op_a),
        .b        (op_b),
        .op       (alu_op_e'(ALUop)),
        .result_c (result)
    );

    // ALU result is the byte address; the word index wraps with the RAM size
    assign idx       = result[IDX_W+1:2];
    assign rd_word   = mem[idx];
    assign lane_byte = rd_word[{result[1:0], 3'b000} +: 8];
    assign lane_half = result[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (mem_op_e'(MemOp))
            MEM_B:   load_val = {{24{lane_byte[7]}}, lane_byte};
            MEM_H:   load_val = {{16{lane_half[15]}}, lane_half};
            MEM_BU:  load_val = {24'd0, lane_byte};
            MEM_HU:  load_val = {16'd0, lane_half};
            default: load_val = rd_word;
        endcase
    end

    // Store width comes from the low funct3 bits: 00 byte, 01 half, else word
    always_comb begin
        st_req.be    = 4'b1111;
        st_req.wdata = data2;
        case (MemOp[1:0])
            2'b00: begin
                st_req.be    = 4'(4'b0001 << result[1:0]);
                st_req.wdata = {4{data2[7:0]}};
            end
            2'b01: begin
                st_req.be    = result[1] ? 4'b1100 : 4'b0011;
                st_req.wdata = {2{data2[15:0]}};
            end
            default: begin
                st_req.be    = 4'b1111;
                st_req.wdata = data2;
            end
        endcase
    end

    assign wr_en = MemWrite & ~rst & ~ebreak;

    // RAM contents survive reset, so this array has no reset branch
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (st_req.be[i]) begin
                    mem[idx][8*i +: 8] <= st_req.wdata[8*i +: 8];
                end
            end
        end
    end

    assign taken     = PCAsrc | (branch & result[0]);
    assign pc_base   = PCBsrc ? data1 : pc;
    assign pc_sum    = pc_base + (taken ? imm : XLEN'(4));
    assign pc_target = PCBsrc ? {pc_sum[XLEN-1:1], 1'b0} : pc_sum;

    assign pc_next  = rst ? RESET_PC : (ebreak ? pc : pc_target);
    assign data_out = rst ? '0 : (MemRead ? load_val : result);

endmodule

// File: tb/tb_exu.sv
// Directed and randomized bench for exu against a byte-addressed reference model.
module tb_exu;

    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned MEM_BYTES = 4 * MEM_WORDS;

    logic        clk;
    logic        rst;
    logic [31:0] pc, imm, data1, data2;
    logic [1:0]  alu_a_src, alu_b_src;
    logic [3:0]  alu_op;
    logic        mem_write, mem_read;
    logic [2:0]  mem_op;
    logic        pc_a_src, pc_b_src, branch, ebreak;
    logic [31:0] data_out, pc_next;

    int checks;
    int failures;

    logic [7:0] ref_mem [MEM_BYTES];

    exu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .imm      (imm),
        .data1    (data1),
        .data2    (data2),
        .ALUAsrc  (alu_a_src),
        .ALUBsrc  (alu_b_src),
        .ALUop    (alu_op),
        .MemWrite (mem_write),
        .MemRead  (mem_read),
        .MemOp    (mem_op),
        .PCAsrc   (pc_a_src),
        .PCBsrc   (pc_b_src),
        .branch   (branch),
        .ebreak   (ebreak),
        .data_out (data_out),
        .pc_next  (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = int'(b % 32);
        case (op)
            4'd0, 4'd15: r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  r = (a < b) ? 32'd1 : 32'd0;
            4'd5:  r = a ^ b;
            4'd6:  r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31]) for (int k = 0; k < sh; k++) r[31-k] = 1'b1;
            end
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: r = b;
            4'd11: r = (a == b) ? 32'd1 : 32'd0;
            4'd12: r = (a != b) ? 32'd1 : 32'd0;
            4'd13: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            default: r = (a >= b) ? 32'd1 : 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] a, b;
        a = (alu_a_src == 2'd0) ? data1 : (alu_a_src == 2'd1) ? pc : 32'd0;
        b = (alu_b_src == 2'd0) ? data2 : (alu_b_src == 2'd1) ? imm :
            (alu_b_src == 2'd2) ? 32'd4 : 32'd0;
        return m_alu(alu_op, a, b);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [2:0] op);
        int unsigned a;
        logic [7:0]  bv;
        logic [15:0] hv;
        a  = addr % MEM_BYTES;
        bv = ref_mem[a];
        hv = {ref_mem[(a & ~1) + 1], ref_mem[a & ~1]};
        case (op)
            3'b000: return {{24{bv[7]}}, bv};
            3'b001: return {{16{hv[15]}}, hv};
            3'b100: return {24'd0, bv};
            3'b101: return {16'd0, hv};
            default: return {ref_mem[(a & ~3) + 3], ref_mem[(a & ~3) + 2],
                             ref_mem[(a & ~3) + 1], ref_mem[a & ~3]};
        endcase
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] d);
        int unsigned a;
        a = addr % MEM_BYTES;
        case (op[1:0])
            2'b00: ref_mem[a] = d[7:0];
            2'b01: begin
                ref_mem[a & ~1]       = d[7:0];
                ref_mem[(a & ~1) + 1] = d[15:8];
            end
            default: for (int k = 0; k < 4; k++) ref_mem[(a & ~3) + k] = d[8*k +: 8];
        endcase
    endtask

    function automatic logic [31:0] m_pc_next();
        logic [31:0] t;
        logic        tk;
        if (ebreak) return pc;
        tk = pc_a_src | (branch & m_result() != 32'd0 && m_result() % 2 == 1);
        t  = (pc_b_src ? data1 : pc) + (tk ? imm : 32'd4);
        if (pc_b_src) t = t & 32'hFFFF_FFFE;
        return t;
    endfunction

    task automatic idle();
        pc = 32'h8000_0000; imm = '0; data1 = '0; data2 = '0;
        alu_a_src = '0; alu_b_src = '0; alu_op = '0;
        mem_write = 1'b0; mem_read = 1'b0; mem_op = 3'b010;
        pc_a_src = 1'b0; pc_b_src = 1'b0; branch = 1'b0; ebreak = 1'b0;
    endtask

    // Address is formed as zero + imm so the ALU result is exactly imm
    task automatic mem_access(input logic [31:0] addr, input logic [2:0] op,
                              input logic wr, input logic [31:0] d);
        idle();
        alu_a_src = 2'd2; alu_b_src = 2'd1; imm = addr;
        mem_op = op; mem_write = wr; mem_read = ~wr; data2 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        #2;
        chk("reset_pc_next", pc_next, 32'h8000_0000);
        chk("reset_data_out", data_out, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fill the RAM so every later load has a known value
        for (int i = 0; i < MEM_WORDS; i++) begin
            w = $urandom();
            mem_access(32'(4 * i), 3'b010, 1'b1, w);
            tick();
            m_store(32'(4 * i), 3'b010, w);
        end
        idle();

        data1 = 32'd5; data2 = 32'd7; #1;
        chk("add_data_out", data_out, 32'd12);
        chk("add_pc_next", pc_next, 32'h8000_0004);

        idle();
        alu_op = 4'd12; data1 = 32'd1; data2 = 32'd2; branch = 1'b1;
        imm = 32'hFFFF_FFF8; pc = 32'h8000_0010; #1;
        chk("bne_taken", pc_next, 32'h8000_0008);
        data1 = 32'd2; #1;
        chk("bne_not_taken", pc_next, 32'h8000_0014);

        idle();
        pc_a_src = 1'b1; pc_b_src = 1'b1; data1 = 32'h8000_0101; imm = 32'd4;
        alu_a_src = 2'd1; alu_b_src = 2'd2; pc = 32'h8000_0020; #1;
        chk("jalr_pc_next", pc_next, 32'h8000_0104);
        chk("jalr_link", data_out, 32'h8000_0024);

        mem_access(32'h10, 3'b010, 1'b1, 32'h8899_AABB);
        tick();
        m_store(32'h10, 3'b010, 32'h8899_AABB);
        mem_access(32'h10, 3'b000, 1'b0, 32'd0); #1;
        chk("lb_0x10", data_out, 32'hFFFF_FFBB);
        mem_access(32'h13, 3'b100, 1'b0, 32'd0); #1;
        chk("lbu_0x13", data_out, 32'h0000_0088);
        mem_access(32'h12, 3'b001, 1'b0, 32'd0); #1;
        chk("lh_0x12", data_out, 32'hFFFF_8899);
        mem_access(32'(MEM_BYTES + 32'h10), 3'b010, 1'b0, 32'd0); #1;
        chk("lw_wrap", data_out, 32'h8899_AABB);
        mem_access(32'h11, 3'b001, 1'b1, 32'h0000_1234);
        tick();
        m_store(32'h11, 3'b001, 32'h0000_1234);
        mem_access(32'h10, 3'b010, 1'b0, 32'd0); #1;
        chk("sh_odd_addr", data_out, 32'h8899_1234);

        idle();
        data1 = 32'h8000_0000; alu_b_src = 2'd1; imm = 32'd4; alu_op = 4'd7; #1;
        chk("sra", data_out, 32'hF800_0000);
        idle();
        data1 = 32'hFFFF_FFFF; data2 = 32'd1; alu_op = 4'd4; #1;
        chk("sltu", data_out, 32'd0);

        mem_access(32'h20, 3'b010, 1'b1, 32'hDEAD_BEEF);
        ebreak = 1'b1; pc = 32'h8000_0040; #1;
        chk("ebreak_pc_hold", pc_next, 32'h8000_0040);
        tick();
        mem_access(32'h20, 3'b010, 1'b0, 32'd0); #1;
        chk("ebreak_no_store", data_out, m_load(32'h20, 3'b010));

        mem_access(32'h24, 3'b010, 1'b1, 32'h1357_9BDF);
        pc = 32'h8000_0100;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_pc", pc_next, 32'h8000_0000);
        chk("rst_async_data", data_out, 32'd0);
        tick();
        rst = 1'b0;
        mem_access(32'h24, 3'b010, 1'b0, 32'd0); #1;
        chk("rst_no_store", data_out, m_load(32'h24, 3'b010));

        // Randomized mix of ALU, branch, jump and memory traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] exp_d, exp_pc, res;
            idle();
            pc        = $urandom();
            imm       = $urandom();
            data1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            data2     = ($urandom_range(0, 3) == 0) ? data1 : $urandom();
            alu_a_src = 2'($urandom_range(0, 3));
            alu_b_src = 2'($urandom_range(0, 3));
            alu_op    = 4'($urandom_range(0, 15));
            mem_op    = 3'($urandom_range(0, 7));
            mem_read  = ($urandom_range(0, 2) == 0);
            mem_write = ($urandom_range(0, 3) == 0);
            pc_a_src  = ($urandom_range(0, 3) == 0);
            pc_b_src  = ($urandom_range(0, 3) == 0);
            branch    = ($urandom_range(0, 1) == 1);
            ebreak    = ($urandom_range(0, 9) == 0);
            #1;
            res    = m_result();
            exp_d  = mem_read ? m_load(res, mem_op) : res;
            exp_pc = m_pc_next();
            chk("rand_data_out", data_out, exp_d);
            chk("rand_pc_next", pc_next, exp_pc);
            tick();
            if (mem_write && !ebreak) m_store(res, mem_op, data2);
        end

        // Read the whole RAM back against the model
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_access(32'(4 * i), 3'b010, 1'b0, 32'd0); #1;
            chk("final_ram", data_out, m_load(32'(4 * i), 3'b010));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
